// File: rtl/simplebus_pkg.sv
// Shared SimpleBus types: FSM states, the latched request record and a byte-lane merge helper.
package simplebus_pkg;

  localparam int BUS_DW = 32;
  localparam int BUS_BW = BUS_DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [BUS_DW-1:0] addr;
    logic              wen;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_BW-1:0] wmask;
  } req_t;

  // Replace the bytes of old_word selected by mask with the matching bytes of new_word.
  function automatic logic [BUS_DW-1:0] apply_wmask(input logic [BUS_DW-1:0] old_word,
                                                    input logic [BUS_DW-1:0] new_word,
                                                    input logic [BUS_BW-1:0] mask);
    logic [BUS_DW-1:0] merged;
    merged = old_word;
    for (int b = 0; b < BUS_BW; b++) begin
      if (mask[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/simplebus_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps only when adv is high.
module simplebus_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  // seed is expected to be tied to a constant, so the reset value is fixed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= seed;
    end else if (adv) begin
      q <= {q[6:0], feedback};
    end
  end

endmodule

// File: rtl/simplebus_sram_responder.sv
// SimpleBus responder backed by a word-addressed storage array.
// Handles one request at a time with a fixed latency plus optional LFSR jitter.
module simplebus_sram_responder
  import simplebus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter int          RAND_DELAY  = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BUS_DW-1:0] req_addr,
  input  logic              req_wen,
  input  logic [BUS_DW-1:0] req_wdata,
  input  logic [BUS_BW-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [BUS_DW-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

  state_e            state;
  req_t              req_q;
  logic [4:0]        cnt;
  logic [7:0]        lfsr_q;
  logic [4:0]        extra;
  logic              accept;
  logic              fire;
  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [BUS_DW-1:0] mem [DEPTH_WORDS];

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign fire     = (state == WAIT) && (cnt == 5'd0);
  // Unsigned subtraction makes addresses below the base wrap high and fail the range test.
  assign offset   = req_q.addr - ADDR_BASE;
  assign in_range = offset < SPAN;
  assign idx      = offset[IDX_W+1:2];
  assign extra    = (RAND_DELAY != 0) ? 5'(lfsr_q & 8'h03) : 5'd0;

  simplebus_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (accept),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // NOTE: the storage array has no reset branch; clearing it would defeat RAM inference
  // and the contents are allowed to survive reset. fire is derived from reset state, so a
  // reset during WAIT can never commit the pending write.
  always_ff @(posedge clk) begin
    if (fire && req_q.wen && in_range) begin
      mem[idx] <= apply_wmask(mem[idx], req_q.wdata, req_q.wmask);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_q      <= '0;
      cnt        <= 5'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_q     <= '{addr: req_addr, wen: req_wen, wdata: req_wdata, wmask: req_wmask};
            cnt       <= 5'(LATENCY - 1) + extra;
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 5'd0) begin
            resp_valid <= 1'b1;
            resp_err   <= !in_range;
            resp_rdata <= (in_range && !req_q.wen) ? mem[idx] : '0;
            state      <= RESP;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simplebus_sram_responder.sv
// Randomized self-checking bench: a LATENCY=1 responder and a LATENCY=3 jittered responder
// checked against a shadow memory and a reference LFSR delay model.
module tb_simplebus_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cur_sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        resp_ready = 1'b1;

  logic        req_ready_a, resp_valid_a, resp_err_a;
  logic [31:0] resp_rdata_a;
  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b;

  logic        s_ready, s_valid, s_err;
  logic [31:0] s_rdata;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model [int];
  logic [7:0]  m_lfsr = 8'hA5;

  always #5 clk = ~clk;

  simplebus_sram_responder dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~cur_sel), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
  );

  simplebus_sram_responder #(.LATENCY(3), .RAND_DELAY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & cur_sel), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
  );

  assign s_ready = cur_sel ? req_ready_b  : req_ready_a;
  assign s_valid = cur_sel ? resp_valid_b : resp_valid_a;
  assign s_err   = cur_sel ? resp_err_b   : resp_err_a;
  assign s_rdata = cur_sel ? resp_rdata_b : resp_rdata_a;

  function automatic int mkey(input bit sel, input logic [31:0] addr);
    return (sel ? 4096 : 0) + int'((addr - BASE) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic bit in_rng(input logic [31:0] addr);
    return (addr - BASE) < 32'd4096;
  endfunction

  // One full transaction; checks handshake, latency, hold stability and completion.
  task automatic txn(input bit sel, input logic [31:0] a, input bit we, input logic [31:0] wd,
                     input logic [3:0] wm, input int hold,
                     output logic [31:0] rdata, output logic err, output int gap);
    int n;
    int exp_gap;
    cur_sel    = sel;
    resp_ready = (hold == 0);
    @(negedge clk);
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_ready_timeout: got %b want 1", s_ready);
      rdata = 'x; err = 1'bx; gap = -1;
      return;
    end
    req_valid = 1'b1; req_addr = a; req_wen = we; req_wdata = wd; req_wmask = wm;
    if (sel) begin
      exp_gap = 3 + int'(m_lfsr[1:0]);
      m_lfsr  = lfsr_step(m_lfsr);
    end else begin
      exp_gap = 1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wen = 1'($urandom); req_wdata = $urandom; req_wmask = 4'($urandom);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (s_valid !== 1'b1 && gap < 40);
    tests++;
    if (gap != exp_gap || s_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency: got %0d cycles (valid=%b) want %0d", gap, s_valid, exp_gap);
    end
    rdata = s_rdata;
    err   = s_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      tests++;
      if (s_valid !== 1'b1 || s_rdata !== rdata || s_err !== err || s_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                 k, s_valid, s_rdata, s_err, s_ready, rdata, err);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (s_valid !== 1'b0 || s_rdata !== 32'h0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL resp_done: got valid=%b rdata=%h ready=%b want 0/00000000/1",
               s_valid, s_rdata, s_ready);
    end
  endtask

  // Transaction plus data/err comparison against the shadow memory.
  task automatic op(input bit sel, input logic [31:0] a, input bit we, input logic [31:0] wd,
                    input logic [3:0] wm, input int hold, input string name);
    logic [31:0] rd, exp_rd;
    logic        er;
    int          g;
    bit          ok;
    int          key;
    ok  = in_rng(a);
    key = mkey(sel, a);
    if (!ok || we) exp_rd = 32'h0;
    else exp_rd = model.exists(key) ? model[key] : 32'hx;
    txn(sel, a, we, wd, wm, hold, rd, er, g);
    if (ok && we) model[key] = merge(model.exists(key) ? model[key] : 32'h0, wd, wm);
    tests++;
    if (rd !== exp_rd || er !== !ok) begin
      fails++;
      $display("FAIL %s: addr=%h got rdata=%h err=%b want rdata=%h err=%b",
               name, a, rd, er, exp_rd, !ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests++;
    if ({req_ready_a, resp_valid_a, resp_err_a, req_ready_b, resp_valid_b, resp_err_b} !== 6'b0 ||
        resp_rdata_a !== 32'h0 || resp_rdata_b !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got a=%b%b%b/%h b=%b%b%b/%h want all 0",
               req_ready_a, resp_valid_a, resp_err_a, resp_rdata_a,
               req_ready_b, resp_valid_b, resp_err_b, resp_rdata_b);
    end
    @(negedge clk);
    rst    = 1'b1;
    m_lfsr = 8'hA5;
  endtask

  task automatic test_basic();
    op(0, 32'h8000_0010, 1, 32'hDEAD_BEEF, 4'hF, 0, "basic_write");
    op(0, 32'h8000_0010, 0, 32'h0, 4'h0, 0, "basic_read");
    op(0, 32'h8000_0013, 0, 32'h0, 4'h0, 0, "unaligned_read");
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd;
    logic        er;
    int          g;
    op(0, 32'h8000_0020, 1, 32'h1122_3344, 4'hF, 0, "mask_init");
    op(0, 32'h8000_0020, 1, 32'hAABB_CCDD, 4'b0101, 0, "mask_write");
    txn(0, 32'h8000_0020, 0, 32'h0, 4'h0, 0, rd, er, g);
    tests++;
    if (rd !== 32'h11BB_33DD) begin
      fails++;
      $display("FAIL byte_mask: got %h want 11bb33dd", rd);
    end
    op(0, 32'h8000_0020, 1, 32'hFFFF_FFFF, 4'h0, 0, "mask_zero_write");
    op(0, 32'h8000_0020, 0, 32'h0, 4'h0, 0, "mask_zero_read");
  endtask

  task automatic test_backpressure();
    op(0, 32'h8000_0010, 0, 32'h0, 4'h0, 5, "backpressure_read");
  endtask

  task automatic test_out_of_range();
    op(0, 32'h8000_0000, 1, 32'h5A5A_1234, 4'hF, 0, "oor_init");
    op(0, 32'h8000_0FFC, 1, 32'hCAFE_F00D, 4'hF, 0, "last_word_write");
    op(0, 32'h7FFF_FFFC, 0, 32'h0, 4'h0, 0, "oor_read_below");
    op(0, 32'h8000_1000, 1, 32'hFFFF_FFFF, 4'hF, 0, "oor_write_above");
    op(0, 32'h8000_0000, 0, 32'h0, 4'h0, 0, "oor_readback_w0");
    op(0, 32'h8000_0FFC, 0, 32'h0, 4'h0, 0, "last_word_read");
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    for (int i = 0; i < 8; i++) begin
      pool[i] = BASE + 32'(i == 0 ? 1023 : $urandom_range(64, 1022)) * 4;
      op(0, pool[i] + 32'($urandom_range(0, 3)), 1, $urandom, 4'hF, 0, "rand_init");
    end
    for (int i = 0; i < 40; i++) begin
      op(0, pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3)), 1'($urandom),
         $urandom, 4'($urandom), $urandom_range(0, 2), "rand_op");
    end
  endtask

  task automatic test_rand_delay();
    logic [31:0] rd;
    logic        er;
    int          g;
    for (int i = 0; i < 4; i++) op(1, BASE + 32'(i * 4), 1, $urandom, 4'hF, 0, "rd_init");
    for (int i = 0; i < 20; i++) begin
      txn(1, BASE + 32'((i % 4) * 4), 0, 32'h0, 4'h0, 0, rd, er, g);
      tests++;
      if (g < 3 || g > 6 || rd !== model[mkey(1, BASE + 32'((i % 4) * 4))] || er !== 1'b0) begin
        fails++;
        $display("FAIL rand_delay_read[%0d]: got gap=%0d rdata=%h err=%b want gap 3..6 rdata=%h err=0",
                 i, g, rd, er, model[mkey(1, BASE + 32'((i % 4) * 4))]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    op(1, 32'h8000_0040, 1, 32'h0BAD_F00D, 4'hF, 0, "midrst_init");
    cur_sel = 1'b1;
    @(negedge clk);
    n = 0;
    while (req_ready_b !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_addr = 32'h8000_0040; req_wen = 1'b1;
    req_wdata = 32'h1234_5678; req_wmask = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({req_ready_b, resp_valid_b, resp_err_b} !== 3'b0 || resp_rdata_b !== 32'h0) begin
      fails++;
      $display("FAIL midrst_outputs: got ready=%b valid=%b err=%b rdata=%h want 0/0/0/0",
               req_ready_b, resp_valid_b, resp_err_b, resp_rdata_b);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    m_lfsr = 8'hA5;
    op(1, 32'h8000_0040, 0, 32'h0, 4'h0, 0, "midrst_readback");
    op(0, 32'h8000_0010, 0, 32'h0, 4'h0, 0, "midrst_readback_a");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_mask();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_rand_delay();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simplebus_sram_responder.md
Name: simplebus_sram_responder

Overview:
- Responder (slave) end of the SimpleBus request/response interface driven by the IFU and LSU initiators.
- Accepts one word-wide read or write request at a time, services it against an internal word-addressed storage array after a fixed or pseudo-random latency, and returns a response.
- Replaces the behavioural DPI memory model with synthesizable RTL that also supports delay injection for handshake stress testing.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- LATENCY, 1, minimum cycles from request acceptance to resp_valid; legal range 1..15.
- RAND_DELAY, 0, when 1, adds 0..3 extra cycles per request taken from an LFSR.
- LFSR_SEED, 8'hA5, reset value of the 8-bit LFSR; must be nonzero.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wen  input  1  1 = write, 0 = read.
- req_wdata  input  32  write data.
- req_wmask  input  4  byte-lane write enables; bit i enables byte i.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator consumes the response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  address out of range.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; req_ready=0 while rst=0, then 1 in IDLE; resp_valid=0; resp_rdata=0; resp_err=0; LFSR=LFSR_SEED. The storage array is not cleared.
- FSM states:
  - IDLE: req_ready=1. A request is accepted on an edge where req_valid && req_ready. At acceptance, latch addr, wen, wdata and wmask; load the counter with LATENCY-1+(RAND_DELAY ? lfsr[1:0] : 0); go to WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle. On the edge where the counter is 0, perform the access, set resp_valid=1, and go to RESP. With LATENCY=1 and no random delay, resp_valid is high in the cycle immediately after acceptance, matching the existing memory model.
  - RESP: resp_valid and resp_rdata/resp_err are held stable until resp_ready=1. On that edge, clear resp_valid and resp_rdata and return to IDLE. req_ready is high the following cycle, so there is at most one outstanding request and no same-cycle turnaround.
- Access rules:
  - Word index = (addr - ADDR_BASE) >> 2.
  - In range iff (addr - ADDR_BASE) < 4*DEPTH_WORDS, computed as unsigned 32-bit, so addresses below base wrap to huge values and are out of range.
  - Read: resp_rdata = array word.
  - Write: each byte lane with wmask=1 is updated; resp_rdata = 0.
  - wmask=0 on a write: no change, normal response.
  - Out of range: no array update, resp_rdata=0, resp_err=1.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances only on request acceptance, so the delay sequence depends only on the number of requests.
- Inputs are ignored outside IDLE; req_valid dropping during WAIT or RESP has no effect.
- resp_ready asserted outside RESP is ignored.
- Reset mid-operation: the pending request is discarded and a write not yet committed is not performed; the FSM returns to IDLE.
- Addresses are not checked for alignment; the low 2 bits are silently dropped.

Decomposition:
- Shared package simplebus_pkg:
  - state enum {IDLE, WAIT, RESP}
  - request struct (addr, wen, wdata, wmask)
  - constant BUS_DW=32
  - reused by the future arbiter between IFU and LSU.
- Sub-module simplebus_lfsr8:
  - Ports: clk, rst, adv, seed, q[7:0].
  - Instantiated once; reusable by initiator-side delay injectors.

Test Plan:
- Reset release, LATENCY=1: write 32'hDEADBEEF mask 4'hF to 32'h8000_0010 with resp_ready held 1 -> resp_valid one cycle after acceptance, err=0. A read of the same address then returns 32'hDEADBEEF.
- Byte mask: word holds 32'h11223344; write 32'hAABBCCDD mask 4'b0101, then read -> 32'h11BB33DD.
- Backpressure: read with resp_ready=0 for 5 cycles -> resp_valid and rdata stay stable for all 5 cycles, req_ready=0 throughout, and the response completes on the first resp_ready=1 edge.
- Out of range: read 32'h7FFF_FFFC and write 32'h8000_1000 (DEPTH_WORDS=1024) -> resp_err=1, rdata=0, and the array is unchanged on readback.
- LATENCY=3, RAND_DELAY=1: 20 back-to-back reads -> each acceptance-to-resp_valid gap is in 3..6 cycles and matches a reference LFSR model seeded 8'hA5.
- Reset asserted during WAIT of a write -> outputs clear asynchronously, and a readback after reset shows the old data.
